// File: rtl/la_capture_core.sv
// la_capture_core: single-clock logic-analyzer capture engine.
//   Armed by arm_i, it records data_i into a circular buffer: pre_cnt
//   pre-trigger samples, then waits for a masked level/edge trigger,
//   then fills the rest of the buffer and stops. Reads are re-based so
//   logical address 0 is the oldest sample of the finished capture.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   data_i                  sample bus, written once per cycle while capturing
//   trig_i                  trigger channels
//   arm_i, abort_i          start / cancel capture (abort wins)
//   trig_mask_i/value_i/edge_i/mode_i, pre_cnt_i   configuration, latched on arm
//   rd_addr_i, rd_data_o    logical read port, one cycle latency
//   state_o, triggered_o, done_o, wait_cnt_o       status, all registered
module la_capture_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned TRIG_W = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic [TRIG_W-1:0] trig_edge_i,
  input  logic              trig_mode_i,
  input  logic [AW-1:0]     pre_cnt_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [31:0]       wait_cnt_o
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("la_capture_core: DEPTH must be a power of two and at least 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] PRE_MAX = AW'(DEPTH - 1);

  state_t state_q, state_d;

  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     start_ptr_q;
  logic [AW-1:0]     smp_cnt_q;
  logic [TRIG_W-1:0] trig_prev_q;

  logic [TRIG_W-1:0] cfg_mask_q;
  logic [TRIG_W-1:0] cfg_value_q;
  logic [TRIG_W-1:0] cfg_edge_q;
  logic              cfg_mode_q;
  logic [AW-1:0]     cfg_pre_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              arm_ok_c;
  logic [TRIG_W-1:0] hit_vec_c;
  logic              trig_hit_c;
  logic [AW-1:0]     post_len_c;
  logic              pre_last_c;
  logic              post_last_c;
  logic [AW-1:0]     rd_idx_c;

  logic              wr_en_c;
  logic              cnt_clr_c;
  logic              cnt_inc_c;
  logic              wait_inc_c;
  logic              done_entry_c;

  // Arm is only honoured when idle or finished, and never alongside abort.
  assign arm_ok_c = arm_i && !abort_i && (state_q == ST_IDLE || state_q == ST_DONE);

  // Per-channel hit: level compare or rising edge against last cycle's trig_i.
  assign hit_vec_c = (cfg_edge_q & trig_i & ~trig_prev_q)
                   | (~cfg_edge_q & ~(trig_i ^ cfg_value_q));

  // An empty mask fires immediately regardless of AND/OR mode.
  always_comb begin
    trig_hit_c = 1'b0;
    if (cfg_mask_q == '0) begin
      trig_hit_c = 1'b1;
    end else if (cfg_mode_q) begin
      trig_hit_c = |(hit_vec_c & cfg_mask_q);
    end else begin
      trig_hit_c = &(hit_vec_c | ~cfg_mask_q);
    end
  end

  // Post-trigger samples still needed after the trigger sample.
  assign post_len_c  = PRE_MAX - cfg_pre_q;
  assign pre_last_c  = (AW'(smp_cnt_q + AW'(1)) == cfg_pre_q);
  assign post_last_c = (AW'(smp_cnt_q + AW'(1)) == post_len_c);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_d = (pre_cnt_i == '0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_PRE: begin
          if (pre_last_c) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (trig_hit_c) begin
            state_d = (cfg_pre_q == PRE_MAX) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (post_last_c) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath control strobes decoded from the current/next state.
  always_comb begin
    wr_en_c      = 1'b0;
    cnt_clr_c    = 1'b0;
    cnt_inc_c    = 1'b0;
    wait_inc_c   = 1'b0;
    done_entry_c = 1'b0;
    if (!abort_i) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          cnt_clr_c = arm_ok_c;
        end
        ST_PRE: begin
          wr_en_c   = 1'b1;
          cnt_inc_c = !pre_last_c;
          cnt_clr_c = pre_last_c;
        end
        ST_WAIT: begin
          wr_en_c    = 1'b1;
          wait_inc_c = 1'b1;
          cnt_clr_c  = trig_hit_c;
        end
        ST_POST: begin
          wr_en_c   = 1'b1;
          cnt_inc_c = 1'b1;
        end
        default: ;
      endcase
      done_entry_c = (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  // Pointers, sample counter, trigger history and latched configuration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      smp_cnt_q   <= '0;
      trig_prev_q <= '0;
      cfg_mask_q  <= '0;
      cfg_value_q <= '0;
      cfg_edge_q  <= '0;
      cfg_mode_q  <= 1'b0;
      cfg_pre_q   <= '0;
    end else begin
      trig_prev_q <= trig_i;
      if (arm_ok_c) begin
        wr_ptr_q    <= '0;
        cfg_mask_q  <= trig_mask_i;
        cfg_value_q <= trig_value_i;
        cfg_edge_q  <= trig_edge_i;
        cfg_mode_q  <= trig_mode_i;
        cfg_pre_q   <= pre_cnt_i;
      end else if (wr_en_c) begin
        wr_ptr_q <= AW'(wr_ptr_q + AW'(1));
      end
      if (cnt_clr_c) begin
        smp_cnt_q <= '0;
      end else if (cnt_inc_c) begin
        smp_cnt_q <= AW'(smp_cnt_q + AW'(1));
      end
      // Oldest sample is the slot the final write leaves the pointer on.
      if (done_entry_c) begin
        start_ptr_q <= AW'(wr_ptr_q + AW'(1));
      end
    end
  end

  // Status outputs, registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_o  <= '0;
      triggered_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      if (arm_ok_c) begin
        wait_cnt_o <= '0;
      end else if (wait_inc_c && wait_cnt_o != 32'hFFFF_FFFF) begin
        wait_cnt_o <= wait_cnt_o + 32'd1;
      end
      triggered_o <= (state_d == ST_POST) || (state_d == ST_DONE);
      done_o      <= (state_d == ST_DONE);
    end
  end

  assign state_o = state_q;

  // Capture buffer: one write port, one read port, no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  assign rd_idx_c = AW'(start_ptr_q + rd_addr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem[rd_idx_c];
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core with DEPTH=16: normal capture, edge/OR
// trigger, zero pre-count, full pre-count, abort, arm-ignore, reset, and
// wait counter saturation. data_i counts up by one every cycle, so every
// buffer word is predictable from the data value present at the trigger.
module tb_la_capture_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TRIG_W = 4;
  localparam int unsigned AW     = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [DATA_W-1:0] data_i;
  logic [TRIG_W-1:0] trig_i;
  logic              arm_i;
  logic              abort_i;
  logic [TRIG_W-1:0] trig_mask_i;
  logic [TRIG_W-1:0] trig_value_i;
  logic [TRIG_W-1:0] trig_edge_i;
  logic              trig_mode_i;
  logic [AW-1:0]     pre_cnt_i;
  logic [AW-1:0]     rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [2:0]        state_o;
  logic              triggered_o;
  logic              done_o;
  logic [31:0]       wait_cnt_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [DATA_W-1:0] trig_data;

  always #5 clk = ~clk;

  la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TRIG_W(TRIG_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .trig_i       (trig_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .trig_edge_i  (trig_edge_i),
    .trig_mode_i  (trig_mode_i),
    .pre_cnt_i    (pre_cnt_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .state_o      (state_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .wait_cnt_o   (wait_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock; outputs are stable 1 time unit after the edge, then data advances.
  task automatic tick();
    @(posedge clk);
    #1;
    data_i = data_i + 8'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [DATA_W-1:0] exp);
    rd_addr_i = AW'(addr);
    tick();
    check(tag, 32'(rd_data_o), 32'(exp));
  endtask

  task automatic cfg(input logic [3:0] mask, input logic [3:0] value, input logic [3:0] edg,
                     input logic mode, input int pre);
    trig_mask_i  = mask;
    trig_value_i = value;
    trig_edge_i  = edg;
    trig_mode_i  = mode;
    pre_cnt_i    = AW'(pre);
  endtask

  task automatic arm_pulse();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; data_i = '0; trig_i = '0; arm_i = 1'b0; abort_i = 1'b0;
    rd_addr_i = '0;
    cfg(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    ticks(2);
    rst_i = 1'b0;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_trig", 32'(triggered_o), 32'd0);
    check("rst_wait", wait_cnt_o, 32'd0);
    check("rst_rd", 32'(rd_data_o), 32'd0);
    ticks(2);

    // Level trigger on channel 0, four pre-trigger samples.
    cfg(4'b0001, 4'b0001, 4'b0000, 1'b0, 4);
    arm_pulse();
    check("t1_pre", 32'(state_o), 32'd1);
    ticks(3);
    check("t1_pre_hold", 32'(state_o), 32'd1);
    tick();
    check("t1_wait", 32'(state_o), 32'd2);
    ticks(10);
    check("t1_wait_hold", 32'(state_o), 32'd2);
    trig_i = 4'b0001;
    trig_data = data_i;
    tick();
    check("t1_post", 32'(state_o), 32'd3);
    check("t1_triggered", 32'(triggered_o), 32'd1);
    check("t1_wait_cnt", wait_cnt_o, 32'd11);
    ticks(10);
    check("t1_post_hold", 32'(state_o), 32'd3);
    check("t1_not_done", 32'(done_o), 32'd0);
    tick();
    check("t1_done_state", 32'(state_o), 32'd4);
    check("t1_done", 32'(done_o), 32'd1);
    for (int a = 0; a < 16; a++) read_chk("t1_rd", a, DATA_W'(trig_data - 8'd4 + 8'(a)));
    check("t1_wait_final", wait_cnt_o, 32'd11);
    trig_i = '0;

    // Edge trigger, OR of channels 0 and 1; channel 1 already high at arm.
    cfg(4'b0011, 4'b0000, 4'b0011, 1'b1, 2);
    trig_i = 4'b0010;
    ticks(2);
    arm_pulse();
    check("t2_pre", 32'(state_o), 32'd1);
    check("t2_rearm_done", 32'(done_o), 32'd0);
    ticks(2);
    check("t2_wait", 32'(state_o), 32'd2);
    ticks(5);
    check("t2_no_trig_high", 32'(state_o), 32'd2);
    trig_i = 4'b0000;
    tick();
    check("t2_no_trig_fall", 32'(state_o), 32'd2);
    trig_i = 4'b0010;
    trig_data = data_i;
    tick();
    check("t2_post", 32'(state_o), 32'd3);
    check("t2_wait_cnt", wait_cnt_o, 32'd7);
    ticks(12);
    check("t2_post_hold", 32'(state_o), 32'd3);
    tick();
    check("t2_done", 32'(done_o), 32'd1);
    read_chk("t2_rd_trig", 2, trig_data);
    read_chk("t2_rd_first", 0, DATA_W'(trig_data - 8'd2));
    read_chk("t2_rd_last", 15, DATA_W'(trig_data + 8'd13));
    trig_i = '0;

    // Zero pre-count and empty mask: one WAIT cycle, sixteen samples.
    cfg(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    tick();
    arm_pulse();
    check("t3_wait", 32'(state_o), 32'd2);
    trig_data = data_i;
    tick();
    check("t3_post", 32'(state_o), 32'd3);
    check("t3_wait_cnt", wait_cnt_o, 32'd1);
    ticks(14);
    check("t3_post_hold", 32'(state_o), 32'd3);
    tick();
    check("t3_done", 32'(state_o), 32'd4);
    read_chk("t3_rd0", 0, trig_data);
    read_chk("t3_rd15", 15, DATA_W'(trig_data + 8'd15));

    // Full pre-count: a hit on the first WAIT cycle goes straight to DONE.
    cfg(4'b0001, 4'b0001, 4'b0000, 1'b0, 15);
    trig_i = 4'b0001;
    arm_pulse();
    ticks(14);
    check("t4_pre_hold", 32'(state_o), 32'd1);
    tick();
    check("t4_wait", 32'(state_o), 32'd2);
    trig_data = data_i;
    tick();
    check("t4_done", 32'(state_o), 32'd4);
    check("t4_done_flag", 32'(done_o), 32'd1);
    check("t4_triggered", 32'(triggered_o), 32'd1);
    check("t4_wait_cnt", wait_cnt_o, 32'd1);
    read_chk("t4_rd15", 15, trig_data);
    read_chk("t4_rd0", 0, DATA_W'(trig_data - 8'd15));
    trig_i = '0;

    // Abort in POST, then arm+abort together from IDLE.
    cfg(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    arm_pulse();
    tick();
    check("t5_post", 32'(state_o), 32'd3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5_abort_state", 32'(state_o), 32'd0);
    check("t5_abort_trig", 32'(triggered_o), 32'd0);
    check("t5_abort_done", 32'(done_o), 32'd0);
    arm_i = 1'b1; abort_i = 1'b1;
    tick();
    arm_i = 1'b0; abort_i = 1'b0;
    check("t5_armabort_state", 32'(state_o), 32'd0);
    check("t5_armabort_done", 32'(done_o), 32'd0);

    // Re-arm after abort; an arm pulse with different config during POST is ignored.
    cfg(4'b0001, 4'b0001, 4'b0000, 1'b0, 4);
    arm_pulse();
    ticks(4);
    check("t6_wait", 32'(state_o), 32'd2);
    trig_i = 4'b0001;
    trig_data = data_i;
    tick();
    check("t6_post", 32'(state_o), 32'd3);
    pre_cnt_i = AW'(9);
    trig_mask_i = 4'b0000;
    arm_pulse();
    check("t6_arm_ignored", 32'(state_o), 32'd3);
    ticks(9);
    check("t6_post_hold", 32'(state_o), 32'd3);
    tick();
    check("t6_done", 32'(state_o), 32'd4);
    read_chk("t6_rd_trig", 4, trig_data);
    read_chk("t6_rd0", 0, DATA_W'(trig_data - 8'd4));
    read_chk("t6_rd15", 15, DATA_W'(trig_data + 8'd11));
    trig_i = '0;

    // Reset during WAIT beats a simultaneous arm.
    cfg(4'b0001, 4'b0001, 4'b0000, 1'b0, 0);
    arm_pulse();
    tick();
    check("t7_wait", 32'(state_o), 32'd2);
    check("t7_wait_cnt", wait_cnt_o, 32'd1);
    rst_i = 1'b1; arm_i = 1'b1;
    tick();
    rst_i = 1'b0; arm_i = 1'b0;
    check("t7_rst_state", 32'(state_o), 32'd0);
    check("t7_rst_wait", wait_cnt_o, 32'd0);
    check("t7_rst_trig", 32'(triggered_o), 32'd0);
    check("t7_rst_done", 32'(done_o), 32'd0);
    check("t7_rst_rd", 32'(rd_data_o), 32'd0);

    // Wait counter saturates instead of wrapping.
    arm_pulse();
    ticks(2);
    force dut.wait_cnt_o = 32'hFFFF_FFFD;
    tick();
    release dut.wait_cnt_o;
    ticks(4);
    check("t8_wait_sat", wait_cnt_o, 32'hFFFF_FFFF);
    check("t8_still_wait", 32'(state_o), 32'd2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t8_abort", 32'(state_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/la_capture_core.md
LA_CAPTURE_CORE -- requirements
Module: la_capture_core

Interface
REQ-001 Parameter DATA_W, default 8: sample data width.
REQ-002 Parameter DEPTH, default 256: capture buffer depth, power of two, at least 4; AW = log2(DEPTH).
REQ-003 Parameter TRIG_W, default 4: trigger channel count.
REQ-004 clk_i  in  1: single clock; all logic on its rising edge.
REQ-005 rst_i  in  1: synchronous, active-high reset.
REQ-006 data_i  in  DATA_W: sample bus, captured once per clock.
REQ-007 trig_i  in  TRIG_W: trigger channels.
REQ-008 arm_i  in  1: start-capture pulse.
REQ-009 abort_i  in  1: cancel capture.
REQ-010 trig_mask_i  in  TRIG_W: 1 = channel participates in the trigger.
REQ-011 trig_value_i  in  TRIG_W: level to match, per channel.
REQ-012 trig_edge_i  in  TRIG_W: per channel, 0 = level match, 1 = rising-edge match.
REQ-013 trig_mode_i  in  1: 0 = AND of masked channels, 1 = OR of masked channels.
REQ-014 pre_cnt_i  in  AW: number of pre-trigger samples, 0..DEPTH-1.
REQ-015 rd_addr_i  in  AW: logical read address; 0 = oldest sample.
REQ-016 rd_data_o  out  DATA_W: read data, registered.
REQ-017 state_o  out  3: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
REQ-018 triggered_o  out  1: high in POST and DONE.
REQ-019 done_o  out  1: high in DONE.
REQ-020 wait_cnt_o  out  32: number of cycles spent in WAIT, saturating at 0xFFFFFFFF.

Function
REQ-021 arm_i sampled high in IDLE or DONE latches trig_mask_i, trig_value_i, trig_edge_i, trig_mode_i and pre_cnt_i. It also clears wr_ptr, the sample counter and wait_cnt_o. Next state is PRE, or WAIT if pre_cnt_i = 0.
REQ-022 arm_i in PRE, WAIT or POST is ignored.
REQ-023 In PRE, WAIT and POST, data_i is written each cycle to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
REQ-024 PRE: trigger is ignored. Transition to WAIT on the cycle the pre_cnt-th sample is written.
REQ-025 WAIT: wait_cnt_o increments each cycle. On trigger hit, the sample written that same cycle is the trigger sample and the next state is POST. If the latched pre_cnt = DEPTH-1, the next state is DONE instead.
REQ-026 POST: stays until exactly DEPTH-1-pre_cnt further samples have been written, then DONE. Total samples written from the trigger sample through the last POST sample = DEPTH - pre_cnt.
REQ-027 Per-channel hit:
- level mode: trig_i[n] == value[n]
- edge mode: trig_i[n] & ~trig_prev[n]
REQ-028 trig_prev is a register of trig_i, updated every cycle in every state; reset value 0.
REQ-029 Trigger combination:
- AND mode: all masked hits are true.
- OR mode: any masked hit is true.
- Mask all-zero: trigger fires on the first WAIT cycle in either mode.
REQ-030 On entry to DONE, start_ptr is set to the wr_ptr value after the final write, i.e. the oldest sample. No writes occur in DONE or IDLE.
REQ-031 rd_data_o = mem[(start_ptr + rd_addr_i) mod DEPTH], valid one cycle after rd_addr_i. Reads are legal in any state; content is defined only in DONE. The trigger sample is at logical address pre_cnt.
REQ-032 abort_i high in any state: next state is IDLE and no further writes occur. Buffer content becomes undefined.
REQ-033 abort_i and arm_i high in the same cycle: abort wins.
REQ-034 Trigger condition during abort or arm cycles: no effect.
REQ-035 Buffer is a single-port-write, single-port-read synchronous RAM that infers block RAM. It has no reset.

Reset
REQ-036 rst_i high at a clock edge forces:
- state IDLE, wr_ptr 0, start_ptr 0, sample counter 0, trig_prev 0
- all latched configuration to 0
- wait_cnt_o 0, triggered_o 0, done_o 0, rd_data_o 0
REQ-037 rst_i has priority over arm_i and abort_i. Reset mid-capture discards the capture.

Verification
REQ-038 DEPTH=16, data_i = free-running cycle count, pre_cnt=4, mask=0001, level, value=1. Arm; trig_i[0] rises 10 cycles after WAIT entry -> done_o after 11 more writes; logical reads 0..15 return 16 consecutive values; trigger sample at address 4; wait_cnt_o = 11.
REQ-039 Edge mode, mask=0011, OR mode, trig_i[1] held high from before arm -> no trigger until trig_i[1] falls and rises again or trig_i[0] rises; the rising cycle gives the trigger sample.
REQ-040 pre_cnt=0, mask=0000 -> state sequence IDLE, WAIT (1 cycle), POST, DONE after 16 samples; trigger sample at logical address 0; wait_cnt_o = 1.
REQ-041 pre_cnt=15, trigger hit on first WAIT cycle -> direct WAIT to DONE; trigger sample at logical address 15.
REQ-042 Abort in POST; separately, arm and abort in the same cycle from IDLE -> IDLE the next cycle, done_o 0; re-arm yields a correct capture.
REQ-043 rst_i asserted during WAIT -> all outputs at reset values next cycle; arm_i during POST ignored; wait_cnt_o saturation checked by forcing near-max.
